muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the MULT/DIV/MFHI/MFLO path of the unicycle MIPS core. It accepts an operation code from the ALU control decode, runs a 32-step shift-add multiply or restoring divide, and owns the HI/LO registers. While an operation is in flight it holds the core with a stall. It sits beside the main ALU and is selected by the ULA opcodes 4'b1000 (MULT), 4'b1001 (DIV), 4'b1010 (MFLO) and 4'b1011 (MFHI).

---
 rtl/muldiv_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO: 32-step shift-add multiply and restoring divide.
// Optional feature macro MULDIV_SIGNED_EN: honour is_unsigned and compile in signed magnitude/sign-fix logic.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ula_op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFLO = 4'b1010;
  localparam logic [3:0] OP_MFHI = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               is_div_q, is_div_d;

  logic               is_muldiv;
  logic               accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign is_muldiv = (ula_op == OP_MULT) || (ula_op == OP_DIV);
  assign accept    = start && is_muldiv;

`ifdef MULDIV_SIGNED_EN
  function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dword(input logic [2*WIDTH-1:0] v, input logic neg);
    logic signed [2*WIDTH-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  logic a_neg, b_neg;
  logic neg_q, neg_d;
  logic rneg_q, rneg_d;

  assign a_neg = ~is_unsigned & op_a[WIDTH-1];
  assign b_neg = ~is_unsigned & op_b[WIDTH-1];
  assign a_mag = neg_word(op_a, a_neg);
  assign b_mag = neg_word(op_b, b_neg);

  // Product and quotient share the a^b sign; the remainder follows the dividend.
  always_comb begin
    neg_d  = neg_q;
    rneg_d = rneg_q;
    if (state_q == IDLE && accept) begin
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
    end
  end

  always_ff @(posedge clk) begin
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
  end

  assign prod_fix = neg_dword(acc_q, neg_q);
  assign quot_fix = neg_word(acc_q[WIDTH-1:0], neg_q);
  assign rem_fix  = neg_word(acc_q[2*WIDTH-1:WIDTH], rneg_q);
`else
  logic unused_is_unsigned;

  assign unused_is_unsigned = is_unsigned;
  assign a_mag    = op_a;
  assign b_mag    = op_b;
  assign prod_fix = acc_q;
  assign quot_fix = acc_q[WIDTH-1:0];
  assign rem_fix  = acc_q[2*WIDTH-1:WIDTH];
`endif

  assign addend    = acc_q[0] ? dvs_q : {WIDTH{1'b0}};
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign div_sh    = {acc_q, 1'b0};
  assign div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    is_div_d = is_div_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = (ula_op == OP_DIV);
          if (ula_op == OP_DIV) begin
            dvs_d = b_mag;
            acc_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            dvs_d = a_mag;
            acc_d = {{WIDTH{1'b0}}, b_mag};
            dz_d  = 1'b0;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          // Upper half is the partial remainder, lower half shifts the dividend out and quotient bits in.
          if (div_trial[WIDTH]) begin
            acc_d = div_sh[2*WIDTH-1:0];
          end else begin
            acc_d = {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (is_div_q) begin
          // Dividing by zero leaves |a| as remainder, so the dividend-sign fix reproduces op_a exactly.
          hi_d = rem_fix;
          if (dvs_q == '0) begin
            lo_d = {WIDTH{1'b1}};
            dz_d = 1'b1;
          end else begin
            lo_d = quot_fix;
            dz_d = 1'b0;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    dvs_q    <= dvs_d;
    is_div_q <= is_div_d;
  end

  // A request presented during reset is not accepted, so it must not stall the core either.
  assign stall    = (state_q == IDLE && accept && rst_n) || (state_q != IDLE);
  assign done     = (state_q == FIX);
  assign div_zero = dz_q;

  always_comb begin
    result = '0;
    if (ula_op == OP_MFLO) begin
      result = lo_q;
    end else if (ula_op == OP_MFHI) begin
      result = hi_q;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer; expectations follow the MULDIV_SIGNED_EN build setting.
module tb_muldiv_sequencer;

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFLO = 4'b1010;
  localparam logic [3:0] OP_MFHI = 4'b1011;

`ifdef MULDIV_SIGNED_EN
  localparam logic [31:0] EXP_M1_HI = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_D1_LO = 32'hFFFF_FFFD;
  localparam logic [31:0] EXP_D1_HI = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_M2_HI = 32'h0000_0000;
  localparam logic [31:0] EXP_D2_LO = 32'hFFFF_FFFD;
  localparam logic [31:0] EXP_D2_HI = 32'h0000_0001;
`else
  localparam logic [31:0] EXP_M1_HI = 32'h0000_0004;
  localparam logic [31:0] EXP_D1_LO = 32'h7FFF_FFFC;
  localparam logic [31:0] EXP_D1_HI = 32'h0000_0001;
  localparam logic [31:0] EXP_M2_HI = 32'hFFFF_FFF6;
  localparam logic [31:0] EXP_D2_LO = 32'h0000_0000;
  localparam logic [31:0] EXP_D2_HI = 32'h0000_0007;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ula_op;
  logic        is_unsigned;
  logic [31:0] op_a, op_b;
  logic        stall;
  logic [31:0] result;
  logic        done;
  logic        div_zero;

  int          n_vec = 0;
  int          n_miscmp = 0;
  int          sc, dc;
  logic [31:0] hi, lo, lo_b2b;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ula_op      (ula_op),
    .is_unsigned (is_unsigned),
    .op_a        (op_a),
    .op_b        (op_b),
    .stall       (stall),
    .result      (result),
    .done        (done),
    .div_zero    (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue MULT/DIV, count stall cycles, and switch to MFLO in the done cycle as the core would.
  task automatic run_op(input logic [3:0] op, input logic uns, input logic [31:0] a,
                        input logic [31:0] b, output int stall_cyc, output int done_cyc,
                        output logic [31:0] lo_next);
    @(negedge clk);
    start = 1'b1; ula_op = op; is_unsigned = uns; op_a = a; op_b = b;
    stall_cyc = 0; done_cyc = -1;
    for (int k = 0; k < 64; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      if (!stall) break;
      stall_cyc++;
      if (done) begin
        done_cyc = k;
        start = 1'b1;
        ula_op = OP_MFLO;
      end
    end
    lo_next = result;
    start = 1'b0;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    start = 1'b1; ula_op = OP_MFHI;
    #1 h = result;
    check("mfhi_stall", 32'(stall), 32'd0);
    ula_op = OP_MFLO;
    #1 l = result;
    check("mflo_stall", 32'(stall), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ula_op = 4'd0; is_unsigned = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    read_hilo(hi, lo);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);

    @(negedge clk);
    start = 1'b1; ula_op = 4'b0010; op_a = 32'd9; op_b = 32'd9;
    #1 check("ignored_op_stall", 32'(stall), 32'd0);
    check("ignored_op_result", result, 32'd0);
    @(negedge clk);
    #1 check("ignored_op_stall_next", 32'(stall), 32'd0);
    start = 1'b0;

    run_op(OP_MULT, 1'b0, 32'hFFFF_FFFD, 32'd5, sc, dc, lo_b2b);
    check("mult1_stall_cycles", 32'(sc), 32'd34);
    check("mult1_done_cycle", 32'(dc), 32'd33);
    check("mult1_b2b_mflo", lo_b2b, 32'hFFFF_FFF1);
    read_hilo(hi, lo);
    check("mult1_hi", hi, EXP_M1_HI);
    check("mult1_lo", lo, 32'hFFFF_FFF1);

    run_op(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, sc, dc, lo_b2b);
    read_hilo(hi, lo);
    check("multu_hi", hi, 32'h0000_0004);
    check("multu_lo", lo, 32'hFFFF_FFF1);

    run_op(OP_MULT, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFA, sc, dc, lo_b2b);
    read_hilo(hi, lo);
    check("mult2_hi", hi, EXP_M2_HI);
    check("mult2_lo", lo, 32'h0000_0018);

    run_op(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, sc, dc, lo_b2b);
    check("div1_stall_cycles", 32'(sc), 32'd34);
    check("div1_done_cycle", 32'(dc), 32'd33);
    read_hilo(hi, lo);
    check("div1_lo", lo, EXP_D1_LO);
    check("div1_hi", hi, EXP_D1_HI);

    run_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, sc, dc, lo_b2b);
    read_hilo(hi, lo);
    check("divu_lo", lo, 32'h7FFF_FFFC);
    check("divu_hi", hi, 32'h0000_0001);

    run_op(OP_DIV, 1'b0, 32'd7, 32'hFFFF_FFFE, sc, dc, lo_b2b);
    read_hilo(hi, lo);
    check("div2_lo", lo, EXP_D2_LO);
    check("div2_hi", hi, EXP_D2_HI);

    run_op(OP_DIV, 1'b0, 32'h0000_1234, 32'd0, sc, dc, lo_b2b);
    check("div0_stall_cycles", 32'(sc), 32'd34);
    read_hilo(hi, lo);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h0000_1234);
    check("div0_flag", 32'(div_zero), 32'd1);

    run_op(OP_MULT, 1'b0, 32'd2, 32'd3, sc, dc, lo_b2b);
    read_hilo(hi, lo);
    check("mult_clr_flag", 32'(div_zero), 32'd0);
    check("mult_2x3_lo", lo, 32'd6);
    check("mult_2x3_hi", hi, 32'd0);

    run_op(OP_DIV, 1'b1, 32'h0000_1234, 32'd0, sc, dc, lo_b2b);
    check("div0b_flag", 32'(div_zero), 32'd1);
    run_op(OP_DIV, 1'b1, 32'd100, 32'd7, sc, dc, lo_b2b);
    read_hilo(hi, lo);
    check("div_clr_flag", 32'(div_zero), 32'd0);
    check("div_100_7_lo", lo, 32'd14);
    check("div_100_7_hi", hi, 32'd2);

    // Abort a MULT at CALC step 10 with reset while the core still holds the request.
    @(negedge clk);
    start = 1'b1; ula_op = OP_MULT; is_unsigned = 1'b1; op_a = 32'h1234_5678; op_b = 32'd9;
    repeat (11) @(negedge clk);
    #1 check("pre_reset_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1 check("reset_stall", 32'(stall), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    ula_op = OP_MFLO;
    #1 check("reset_lo", result, 32'd0);
    ula_op = OP_MFHI;
    #1 check("reset_hi", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("post_reset_stall", 32'(stall), 32'd0);

    run_op(OP_MULT, 1'b0, 32'd7, 32'd6, sc, dc, lo_b2b);
    check("mult_7x6_cycles", 32'(sc), 32'd34);
    read_hilo(hi, lo);
    check("mult_7x6_lo", lo, 32'd42);
    check("mult_7x6_hi", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
